// File: rtl/traffic_phase_arbiter.sv
// Demand-actuated round-robin phase arbiter for a 4-way intersection.
// Green has min/max timing with gap-out, fixed yellow/all-red clearance, and preemption.
module traffic_phase_arbiter #(
    parameter int unsigned MIN_GREEN   = 4,
    parameter int unsigned MAX_GREEN   = 12,
    parameter int unsigned YELLOW_TIME = 3,
    parameter int unsigned ALLRED_TIME = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  req,
    input  logic        preempt,
    input  logic [1:0]  preempt_phase,
    output logic [11:0] lamp,
    output logic [1:0]  state,
    output logic [1:0]  phase,
    output logic [3:0]  timer,
    output logic [3:0]  pending
);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StGreen  = 2'd1,
        StYellow = 2'd2,
        StAllRed = 2'd3
    } state_e;

    localparam logic [3:0] MinLim    = 4'(MIN_GREEN - 1);
    localparam logic [3:0] MaxLim    = 4'(MAX_GREEN - 1);
    localparam logic [3:0] YellowLim = 4'(YELLOW_TIME - 1);
    localparam logic [3:0] AllRedLim = 4'(ALLRED_TIME - 1);

    localparam logic [2:0] LampRed    = 3'b100;
    localparam logic [2:0] LampYellow = 3'b010;
    localparam logic [2:0] LampGreen  = 3'b001;

    state_e     r_state;
    logic [1:0] r_phase;
    logic [3:0] r_timer;
    logic [3:0] r_pending;

    logic [1:0] w_rr_pick;
    logic       w_rr_found;
    logic [1:0] w_cand;
    logic [1:0] w_pick;
    logic [3:0] w_phase_oh;
    logic       w_other;
    logic       w_any;
    logic       w_green_exit;
    logic [3:0] w_timer_inc;
    logic [3:0] w_pend_set;
    logic [3:0] w_pend_grant;

    // Scan phase+1 .. phase+3, then phase itself, so the served approach is considered last.
    always_comb begin
        w_rr_pick  = r_phase;
        w_rr_found = 1'b0;
        w_cand     = r_phase;
        for (int k = 1; k <= 4; k++) begin
            w_cand = r_phase + 2'(k);
            if (!w_rr_found && r_pending[w_cand]) begin
                w_rr_pick  = w_cand;
                w_rr_found = 1'b1;
            end
        end
    end

    always_comb begin
        w_pick       = preempt ? preempt_phase : w_rr_pick;
        w_phase_oh   = 4'b0001 << r_phase;
        w_other      = |(r_pending & ~w_phase_oh);
        w_any        = preempt || (r_pending != 4'b0000);
        w_timer_inc  = (r_timer == 4'hF) ? r_timer : r_timer + 4'd1;
        w_pend_set   = r_pending | req;
        // Clearing the granted bit wins over a same-edge request.
        w_pend_grant = w_pend_set & ~(4'b0001 << w_pick);
    end

    always_comb begin
        w_green_exit = 1'b0;
        if (preempt) begin
            w_green_exit = (preempt_phase != r_phase);
        end else if (w_other) begin
            w_green_exit = (r_timer >= MaxLim) || ((r_timer >= MinLim) && !req[r_phase]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= StIdle;
            r_phase   <= 2'd3;
            r_timer   <= 4'd0;
            r_pending <= 4'b0000;
        end else begin
            r_pending <= w_pend_set;
            r_timer   <= w_timer_inc;
            unique case (r_state)
                StIdle: begin
                    if (w_any) begin
                        r_state   <= StGreen;
                        r_phase   <= w_pick;
                        r_timer   <= 4'd0;
                        r_pending <= w_pend_grant;
                    end
                end
                StGreen: begin
                    if (w_green_exit) begin
                        r_state <= StYellow;
                        r_timer <= 4'd0;
                    end
                end
                StYellow: begin
                    if (r_timer == YellowLim) begin
                        r_state <= StAllRed;
                        r_timer <= 4'd0;
                    end
                end
                StAllRed: begin
                    if (r_timer == AllRedLim) begin
                        r_timer <= 4'd0;
                        if (w_any) begin
                            r_state   <= StGreen;
                            r_phase   <= w_pick;
                            r_pending <= w_pend_grant;
                        end else begin
                            r_state <= StIdle;
                        end
                    end
                end
            endcase
        end
    end

    always_comb begin
        lamp = {LampRed, LampRed, LampRed, LampRed};
        for (int i = 0; i < 4; i++) begin
            if (2'(i) == r_phase) begin
                if (r_state == StGreen) begin
                    lamp[3*i +: 3] = LampGreen;
                end else if (r_state == StYellow) begin
                    lamp[3*i +: 3] = LampYellow;
                end
            end
        end
    end

    assign state   = r_state;
    assign phase   = r_phase;
    assign timer   = r_timer;
    assign pending = r_pending;

endmodule

// File: tb/tb_traffic_phase_arbiter.sv
// Table-driven bench for traffic_phase_arbiter: directed vectors with hand-computed
// expected state/phase/timer/pending/lamp, plus looped idle, rest and round-robin sequences.
module tb_traffic_phase_arbiter;

    localparam logic [1:0] SI = 2'd0;
    localparam logic [1:0] SG = 2'd1;
    localparam logic [1:0] SY = 2'd2;
    localparam logic [1:0] SA = 2'd3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic        preempt;
    logic [1:0]  preempt_phase;
    logic [11:0] lamp;
    logic [1:0]  state;
    logic [1:0]  phase;
    logic [3:0]  timer;
    logic [3:0]  pending;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic       rst;
        logic [3:0] rq;
        logic       pre;
        logic [1:0] pp;
        logic [1:0] st;
        logic [1:0] ph;
        logic [3:0] tm;
        logic [3:0] pd;
    } vec_t;

    vec_t vecs[$];

    traffic_phase_arbiter #(
        .MIN_GREEN  (4),
        .MAX_GREEN  (12),
        .YELLOW_TIME(3),
        .ALLRED_TIME(1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .preempt      (preempt),
        .preempt_phase(preempt_phase),
        .lamp         (lamp),
        .state        (state),
        .phase        (phase),
        .timer        (timer),
        .pending      (pending)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] exp_lamp(input logic [1:0] st, input logic [1:0] ph);
        logic [11:0] l;
        l = 12'b100100100100;
        if (st == SG) l[3*ph +: 3] = 3'b001;
        if (st == SY) l[3*ph +: 3] = 3'b010;
        return l;
    endfunction

    task automatic check(input string nm, input int act, input int want);
        n_cmp++;
        if (act != want) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, want);
        end
    endtask

    task automatic add(input logic rst, input logic [3:0] rq, input logic pre,
                       input logic [1:0] pp, input logic [1:0] st, input logic [1:0] ph,
                       input logic [3:0] tm, input logic [3:0] pd);
        vec_t v;
        v.rst = rst; v.rq = rq; v.pre = pre; v.pp = pp;
        v.st = st; v.ph = ph; v.tm = tm; v.pd = pd;
        vecs.push_back(v);
    endtask

    // Each vector: drive inputs, then either one clock edge or an async reset pulse, then compare.
    task automatic run_table(input string tag);
        foreach (vecs[i]) begin
            req           = vecs[i].rq;
            preempt       = vecs[i].pre;
            preempt_phase = vecs[i].pp;
            if (vecs[i].rst) begin
                rst_n = 1'b0;
                #2;
            end else begin
                @(posedge clk);
                #1;
            end
            check($sformatf("%s[%0d].state", tag, i), int'(state), int'(vecs[i].st));
            check($sformatf("%s[%0d].phase", tag, i), int'(phase), int'(vecs[i].ph));
            check($sformatf("%s[%0d].timer", tag, i), int'(timer), int'(vecs[i].tm));
            check($sformatf("%s[%0d].pending", tag, i), int'(pending), int'(vecs[i].pd));
            check($sformatf("%s[%0d].lamp", tag, i), int'(lamp),
                  int'(exp_lamp(vecs[i].st, vecs[i].ph)));
            if (vecs[i].rst) rst_n = 1'b1;
        end
        vecs.delete();
    endtask

    initial begin
        logic [1:0] order [5];
        logic [1:0] prev_st;
        int         gcount;
        int         glen;
        int         ends;
        int         nonred;

        rst_n         = 1'b0;
        req           = 4'b0000;
        preempt       = 1'b0;
        preempt_phase = 2'd0;
        @(posedge clk);
        #1;
        check("reset.state", int'(state), 0);
        check("reset.phase", int'(phase), 3);
        check("reset.timer", int'(timer), 0);
        check("reset.pending", int'(pending), 0);
        check("reset.lamp", int'(lamp), int'(12'b100100100100));
        rst_n = 1'b1;

        // Idle with no demand; timer saturates at 15.
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("idle[%0d].state", i), int'(state), 0);
            check($sformatf("idle[%0d].pending", i), int'(pending), 0);
            check($sformatf("idle[%0d].lamp", i), int'(lamp), int'(12'b100100100100));
            check($sformatf("idle[%0d].timer", i), int'(timer), (i > 15) ? 15 : i);
        end

        // One-cycle req[2] pulse from IDLE.
        add(0, 4'b0100, 0, 0, SI, 3, 15, 4'b0100);
        add(0, 4'b0000, 0, 0, SG, 2, 0, 4'b0000);
        run_table("pulse2");

        // Uncontested green rests indefinitely.
        for (int i = 1; i <= 32; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("rest[%0d].state", i), int'(state), int'(SG));
            check($sformatf("rest[%0d].phase", i), int'(phase), 2);
            check($sformatf("rest[%0d].timer", i), int'(timer), (i > 15) ? 15 : i);
            check($sformatf("rest[%0d].lamp", i), int'(lamp), int'(12'b100001100100));
        end

        // Max-out of approach 0 (req[0] held), then gap-out of approach 1.
        add(1, 4'b0000, 0, 0, SI, 3, 0, 4'b0000);
        add(0, 4'b0001, 0, 0, SI, 3, 1, 4'b0001);
        add(0, 4'b0001, 0, 0, SG, 0, 0, 4'b0000);
        add(0, 4'b0001, 0, 0, SG, 0, 1, 4'b0001);
        add(0, 4'b0011, 0, 0, SG, 0, 2, 4'b0011);
        for (int t = 3; t <= 11; t++) add(0, 4'b0001, 0, 0, SG, 0, 4'(t), 4'b0011);
        add(0, 4'b0001, 0, 0, SY, 0, 0, 4'b0011);
        add(0, 4'b0001, 0, 0, SY, 0, 1, 4'b0011);
        add(0, 4'b0001, 0, 0, SY, 0, 2, 4'b0011);
        add(0, 4'b0001, 0, 0, SA, 0, 0, 4'b0011);
        add(0, 4'b0001, 0, 0, SG, 1, 0, 4'b0001);
        add(0, 4'b0001, 0, 0, SG, 1, 1, 4'b0001);
        add(0, 4'b0001, 0, 0, SG, 1, 2, 4'b0001);
        add(0, 4'b0001, 0, 0, SG, 1, 3, 4'b0001);
        add(0, 4'b0001, 0, 0, SY, 1, 0, 4'b0001);
        add(0, 4'b0001, 0, 0, SY, 1, 1, 4'b0001);
        add(0, 4'b0001, 0, 0, SY, 1, 2, 4'b0001);
        add(0, 4'b0001, 0, 0, SA, 1, 0, 4'b0001);
        add(0, 4'b0001, 0, 0, SG, 0, 0, 4'b0000);
        run_table("maxgap");

        // Preempt to 3 at green timer=1; preempt_phase wobbles during clearance.
        add(1, 4'b0000, 0, 0, SI, 3, 0, 4'b0000);
        add(0, 4'b0001, 0, 0, SI, 3, 1, 4'b0001);
        add(0, 4'b0000, 0, 0, SG, 0, 0, 4'b0000);
        add(0, 4'b0010, 0, 0, SG, 0, 1, 4'b0010);
        add(0, 4'b0000, 1, 3, SY, 0, 0, 4'b0010);
        add(0, 4'b0000, 1, 2, SY, 0, 1, 4'b0010);
        add(0, 4'b0000, 1, 2, SY, 0, 2, 4'b0010);
        add(0, 4'b0000, 1, 2, SA, 0, 0, 4'b0010);
        add(0, 4'b0000, 1, 3, SG, 3, 0, 4'b0010);
        for (int t = 1; t <= 12; t++) add(0, 4'b0000, 1, 3, SG, 3, 4'(t), 4'b0010);
        add(0, 4'b0000, 0, 0, SY, 3, 0, 4'b0010);
        add(0, 4'b0000, 0, 0, SY, 3, 1, 4'b0010);
        add(0, 4'b0000, 0, 0, SY, 3, 2, 4'b0010);
        add(0, 4'b0000, 0, 0, SA, 3, 0, 4'b0010);
        add(0, 4'b0000, 0, 0, SG, 1, 0, 4'b0000);
        // Reset during yellow drops pending demand.
        add(0, 4'b0100, 0, 0, SG, 1, 1, 4'b0100);
        add(0, 4'b0000, 0, 0, SG, 1, 2, 4'b0100);
        add(0, 4'b0000, 0, 0, SG, 1, 3, 4'b0100);
        add(0, 4'b0000, 0, 0, SY, 1, 0, 4'b0100);
        add(0, 4'b0000, 0, 0, SY, 1, 1, 4'b0100);
        add(1, 4'b0000, 0, 0, SI, 3, 0, 4'b0000);
        add(0, 4'b0000, 0, 0, SI, 3, 1, 4'b0000);
        run_table("preempt");

        // All approaches demanding from reset: order 0,1,2,3,0, each green 12 cycles.
        order[0] = 2'd0; order[1] = 2'd1; order[2] = 2'd2; order[3] = 2'd3; order[4] = 2'd0;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        req     = 4'b1111;
        prev_st = SI;
        gcount  = 0;
        glen    = 0;
        ends    = 0;
        for (int cyc = 0; cyc < 120; cyc++) begin
            @(posedge clk);
            #1;
            nonred = 0;
            for (int a = 0; a < 4; a++) begin
                if (lamp[3*a +: 3] != 3'b100) nonred++;
            end
            check($sformatf("rr[%0d].one_nonred", cyc), int'(nonred <= 1), 1);
            if (state == SG) begin
                if (prev_st != SG) begin
                    if (gcount < 5) begin
                        check($sformatf("rr.order[%0d]", gcount), int'(phase), int'(order[gcount]));
                    end
                    gcount++;
                    glen = 1;
                end else begin
                    glen++;
                end
            end else if (prev_st == SG) begin
                check($sformatf("rr.green_len[%0d]", ends), glen, 12);
                ends++;
            end
            prev_st = state;
            if (ends == 5) break;
        end
        check("rr.greens_completed", ends, 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
